cmp_result_monitor: RTL
=======================

// Module: cmp_result_monitor
// PURPOSE
//   Downstream consumer of comparator_2bit result flags (Lesser/Greater/Equal).
//   Samples one result per valid cycle and checks that exactly one flag is set.
//   Keeps saturating per-category and error counts.
//   Raises Eq_run once Equal has held for RUN_LEN consecutive valid samples (match/lock detect).
// PARAMETERS
//   CNT_W    8   width of each event counter
//   RUN_LEN  4   consecutive valid Equal samples required to assert Eq_run (legal 2..255)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   In_valid   in   1      Lesser/Greater/Equal carry a result this cycle
//   Lesser     in   1      comparator flag A<B
//   Greater    in   1      comparator flag A>B
//   Equal      in   1      comparator flag A==B
//   Clear      in   1      synchronous clear of counters and run FSM
//   Lt_count   out  CNT_W  count of valid Lesser samples (saturating)
//   Gt_count   out  CNT_W  count of valid Greater samples (saturating)
//   Eq_count   out  CNT_W  count of valid Equal samples (saturating)
//   Err_count  out  CNT_W  count of non-one-hot valid samples (saturating)
//   Eq_run     out  1      Equal held >= RUN_LEN consecutive valid samples
//   Flag_err   out  1      1-cycle pulse: last valid sample was not one-hot
//   Out_valid  out  1      1-cycle pulse: outputs reflect a new sample
// BEHAVIOUR
//   Reset: all counters 0, Eq_run=0, Flag_err=0, Out_valid=0, FSM=IDLE. Async assert; release takes effect at the next clk edge.
//   Latency: sample at edge N; counters, Eq_run, Flag_err and Out_valid update at edge N; visible in cycle N+1.
//   Legal sample: In_valid=1 and {Lesser,Greater,Equal} is one of 100/010/001.
//   Illegal sample: In_valid=1 and {L,G,E} in 000/011/101/110/111.
//     - Err_count+1, Flag_err=1 for one cycle.
//     - No category counter changes; FSM -> IDLE.
//   In_valid=0: all state holds and Out_valid=Flag_err=0.
//     - Gaps do not break a run (run counts valid samples only).
//   Counters: +1 per qualifying sample; saturate at 2^CNT_W-1 with no wrap; other counters keep counting.
//   Run FSM (internal run counter rc, 8 bits):
//     IDLE: legal Equal -> RUN, rc=1; anything else stays IDLE.
//     RUN: legal Equal -> rc+1; when rc+1==RUN_LEN -> LOCK.
//          Lesser/Greater/illegal -> IDLE, rc=0.
//     LOCK: Eq_run=1; legal Equal stays LOCK with rc frozen.
//           Lesser/Greater/illegal -> IDLE, Eq_run=0 at the same edge.
//     Eq_run = (state==LOCK), registered.
//   Clear=1: at the next edge all counters=0, FSM=IDLE, Eq_run=0, Flag_err=0, Out_valid=0.
//     - Clear with In_valid in the same cycle: Clear wins and the sample is dropped.
//   Reset mid-run or at saturation: everything returns to reset values immediately.
// TESTING
//   1 Reset: hold rst_n=0 and drive flags -> all outputs 0.
//     Deassert with In_valid=0 for 3 cycles -> outputs stay 0.
//   2 Sweep the 16 {A,B} pairs through comparator_2bit, In_valid=1 each cycle
//     -> Lt=6, Gt=6, Eq=4, Err=0; Out_valid pulses 16 times.
//   3 Equal x3, one In_valid=0 gap, Equal x1 (RUN_LEN=4) -> Eq_run=1 the cycle after the 4th Equal.
//     Then Greater -> Eq_run=0 one cycle later.
//   4 Drive {L,G,E}=110 and 000 with In_valid=1 -> Err_count=2, two Flag_err pulses.
//     Category counts and FSM unchanged, except the FSM returns to IDLE.
//   5 CNT_W=4: drive 20 Lesser samples -> Lt_count stops at 15.
//     Then 1 Equal -> Eq_count=1; Lt_count stays 15.
//   6 Clear asserted with In_valid=1/Equal while in LOCK -> next cycle counters=0, Eq_run=0, Out_valid=0.
//     Assert rst_n=0 mid-run -> outputs 0 asynchronously.

Source files
------------

// File: rtl/cmp_result_monitor.sv
// Consumes comparator_2bit result flags: checks one-hot, keeps saturating
// per-category/error counts and detects a run of RUN_LEN consecutive Equal samples.
module cmp_result_monitor #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In_valid,
    input  logic             Lesser,
    input  logic             Greater,
    input  logic             Equal,
    input  logic             Clear,
    output logic [CNT_W-1:0] Lt_count,
    output logic [CNT_W-1:0] Gt_count,
    output logic [CNT_W-1:0] Eq_count,
    output logic [CNT_W-1:0] Err_count,
    output logic             Eq_run,
    output logic             Flag_err,
    output logic             Out_valid
);

    localparam int unsigned RC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [CNT_W-1:0]  lt_d, gt_d, eq_d, err_d;
    logic              eq_run_d, flag_err_d, out_valid_d;
    logic              legal;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign legal = ({Lesser, Greater, Equal} == 3'b100) ||
                   ({Lesser, Greater, Equal} == 3'b010) ||
                   ({Lesser, Greater, Equal} == 3'b001);

    // Next-state and next-output logic; Clear outranks a same-cycle sample
    always_comb begin
        state_d     = state_q;
        rc_d        = rc_q;
        lt_d        = Lt_count;
        gt_d        = Gt_count;
        eq_d        = Eq_count;
        err_d       = Err_count;
        flag_err_d  = 1'b0;
        out_valid_d = 1'b0;
        if (Clear) begin
            state_d = IDLE;
            rc_d    = '0;
            lt_d    = '0;
            gt_d    = '0;
            eq_d    = '0;
            err_d   = '0;
        end else if (In_valid) begin
            out_valid_d = 1'b1;
            if (!legal) begin
                err_d      = sat_inc(Err_count);
                flag_err_d = 1'b1;
                state_d    = IDLE;
                rc_d       = '0;
            end else if (Equal) begin
                eq_d = sat_inc(Eq_count);
                case (state_q)
                    IDLE: begin
                        state_d = RUN;
                        rc_d    = RC_W'(1);
                    end
                    RUN: begin
                        rc_d = rc_q + RC_W'(1);
                        if (rc_d == RC_W'(RUN_LEN)) state_d = LOCK;
                    end
                    default: state_d = LOCK;
                endcase
            end else begin
                if (Lesser) lt_d = sat_inc(Lt_count);
                if (Greater) gt_d = sat_inc(Gt_count);
                state_d = IDLE;
                rc_d    = '0;
            end
        end
        eq_run_d = (state_d == LOCK);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rc_q      <= '0;
            Lt_count  <= '0;
            Gt_count  <= '0;
            Eq_count  <= '0;
            Err_count <= '0;
            Eq_run    <= 1'b0;
            Flag_err  <= 1'b0;
            Out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            rc_q      <= rc_d;
            Lt_count  <= lt_d;
            Gt_count  <= gt_d;
            Eq_count  <= eq_d;
            Err_count <= err_d;
            Eq_run    <= eq_run_d;
            Flag_err  <= flag_err_d;
            Out_valid <= out_valid_d;
        end
    end

endmodule
